button_debouncer: RTL and testbench
===================================

# button_debouncer

Multi-channel push-button conditioner that sits directly upstream of the push-button memory-mapped peripheral. It takes the raw, asynchronous board button pins and synchronises each one into `clk`. It then filters contact bounce with a per-channel stability counter. Outputs are clean debounced levels plus one-cycle press/release pulses; the peripheral latches the levels into its readable register and drives the CPU interrupt from them.

## Interface
Parameters:
- `N`, 3: number of button channels.
- `STABLE_CYCLES`, 1000000: consecutive cycles a synchronised input must differ from the current output before the output flips (10 ms at 100 MHz). Must be ≥ 2.
- `CNT_W`, `$clog2(STABLE_CYCLES)`: stability counter width, derived and not overridden.

Ports:
- `clk`, in, 1: system clock. All state updates on its rising edge.
- `rst`, in, 1: reset, **synchronous, active-low**.
- `btn_in`, in, N: raw button pins, asynchronous, active-high.
- `db_out`, out, N: debounced level per channel, registered.
- `press_pulse`, out, N: one-cycle pulse when `db_out[i]` goes 0→1, registered.
- `release_pulse`, out, N: one-cycle pulse when `db_out[i]` goes 1→0, registered.
- `any_press`, out, 1: registered OR of the next-cycle `press_pulse` bits. It rises in the same cycle as any `press_pulse` bit.

## Operation
- **Synchroniser.** Per channel, a two-flop chain `s1[i] <= btn_in[i]; s2[i] <= s1[i]`. Only `s2` feeds the filter.
- **Per-channel filter** (independent counter `cnt[i]`, CNT_W bits), evaluated every edge:
  - If `s2[i] == db_out[i]`: `cnt[i] <= 0`. This covers any bounce back to the current level, which restarts the count.
  - If `s2[i] != db_out[i]` and `cnt[i] == STABLE_CYCLES-1`: `db_out[i] <= s2[i]` and `cnt[i] <= 0`.
  - Otherwise: `cnt[i] <= cnt[i] + 1`.
  - The counter never exceeds `STABLE_CYCLES-1`, so it has no wrap-around.
- **Edge pulses.** They are registered alongside the `db_out` update:
  - `press_pulse[i] <= 1` exactly in the edge where `db_out[i]` flips 0→1, else 0.
  - `release_pulse[i]` likewise for a 1→0 flip.
  - `press_pulse[i]` and `release_pulse[i]` are never high together.
- **`any_press`.** Asserted for exactly one cycle in the same cycle as any `press_pulse` bit. Simultaneous presses on several channels produce a single one-cycle `any_press`.
- **Reset** (`rst == 0` at an edge):
  - `s1`, `s2`, all `cnt`, `db_out`, `press_pulse`, `release_pulse` and `any_press` are cleared to 0.
  - Reset overrides any in-progress count. A button held through reset deasserts at the edge and re-qualifies only after the full synchroniser and filter latency once `rst` returns to 1. No pulse is emitted for the forced clear.

## Timing
- Let `btn_in[i]` change before edge k and stay stable.
  - `s2[i]` shows the new value after edge k+1.
  - Mismatch is counted at edges k+2 … k+1+STABLE_CYCLES.
  - `db_out[i]` and the matching pulse change after edge k+1+STABLE_CYCLES.
  - Total latency: STABLE_CYCLES+2 cycles, identical for press and release.
- A glitch shorter than STABLE_CYCLES synchronised cycles never changes `db_out`.
- A glitch of exactly STABLE_CYCLES cycles does flip `db_out`.
- Pulses last exactly one cycle.
- The minimum spacing between a press pulse and a release pulse on the same channel is STABLE_CYCLES cycles.
- Channels are fully independent: simultaneous events on different channels each follow the rule above with no interaction.

## Test plan
All scenarios use `N=3`, `STABLE_CYCLES=4`.
1. **Reset.** Hold `rst=0` for 3 cycles with `btn_in=3'b111` → all outputs 0 throughout. Release `rst` → `db_out=3'b111` exactly 6 edges later, together with `press_pulse=3'b111` and `any_press=1` for one cycle.
2. **Clean press.** Set `btn_in[0]` 0→1 before edge k → `db_out[0]=1` and `press_pulse[0]=1` after edge k+5. Both `press_pulse[0]` and `any_press` are back to 0 after edge k+6.
3. **Bounce rejection.** Drive `btn_in[1]` with 1,1,1,0,1,1,1,0 (3 high cycles each time) → `db_out[1]` stays 0 and no pulses. Then hold it at 1 → `db_out[1]` rises 6 cycles after the last 0→1 change.
4. **Clean release.** With `db_out[2]=1`, set `btn_in[2]=0` → `release_pulse[2]` for one cycle 6 cycles later, `press_pulse` stays 0, `any_press` stays 0.
5. **Simultaneous plus reset mid-count.**
   - Press channels 0 and 1 on the same edge → both `db_out` bits flip on the same edge, with a single one-cycle `any_press`.
   - Then start a press on channel 2 and assert `rst=0` after 2 counted cycles → `cnt` clears and `db_out[2]` stays 0.
   - Deassert `rst` → `db_out[2]` rises 6 edges later.

Source files
------------

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - multi-channel push-button synchroniser and debouncer with edge pulses
module button_debouncer #(
    parameter int N             = 3,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] db_out,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic         any_press
);

    // Terminal count: a mismatch seen while the counter holds this value flips the output.
    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [N-1:0]     r_s1;
    logic [N-1:0]     r_s2;
    logic [CNT_W-1:0] r_cnt [N];

    logic [N-1:0]     w_db_next;
    logic [N-1:0]     w_press_next;
    logic [N-1:0]     w_release_next;
    logic [CNT_W-1:0] w_cnt_next [N];

    // Per-channel stability filter: count consecutive mismatches, flip on the last one.
    always_comb begin
        w_db_next      = db_out;
        w_press_next   = '0;
        w_release_next = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt_next[i] = '0;
            if (r_s2[i] != db_out[i]) begin
                if (r_cnt[i] == LP_CNT_MAX) begin
                    w_db_next[i]      = r_s2[i];
                    w_press_next[i]   = r_s2[i];
                    w_release_next[i] = ~r_s2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Synchroniser, counters and registered outputs; reset forces a silent clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1          <= '0;
            r_s2          <= '0;
            db_out        <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            any_press     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1          <= btn_in;
            r_s2          <= r_s1;
            db_out        <= w_db_next;
            press_pulse   <= w_press_next;
            release_pulse <= w_release_next;
            any_press     <= |w_press_next;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - randomized self-checking bench for button_debouncer
module tb_button_debouncer;

    localparam int N = 3;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] db_out;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic         any_press;

    button_debouncer #(
        .N            (N),
        .STABLE_CYCLES(S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .db_out       (db_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .any_press    (any_press)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_no  = 0;

    // Reference: the level the filter sees is btn_in delayed two edges; the output
    // flips once S consecutive edges since the last match/flip/reset all mismatched.
    logic [N-1:0] m_dly1 = '0;
    logic [N-1:0] m_dly2 = '0;
    logic [N-1:0] m_db = '0;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel = '0;
    logic         m_any = 1'b0;
    int           anchor [N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edge_no);
    endtask

    task automatic step();
        @(posedge clk);
        edge_no++;
        m_press = '0;
        m_rel   = '0;
        if (!rst) begin
            m_dly1 = '0;
            m_dly2 = '0;
            m_db   = '0;
            for (int i = 0; i < N; i++) anchor[i] = edge_no;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_dly2[i] == m_db[i]) begin
                    anchor[i] = edge_no;
                end else if (edge_no - anchor[i] >= S) begin
                    m_db[i]    = m_dly2[i];
                    m_press[i] = m_dly2[i];
                    m_rel[i]   = ~m_dly2[i];
                    anchor[i]  = edge_no;
                end
            end
            m_dly2 = m_dly1;
            m_dly1 = btn_in;
        end
        m_any = |m_press;
        #1;
        check_eq("db_out", 32'(db_out), 32'(m_db));
        check_eq("press_pulse", 32'(press_pulse), 32'(m_press));
        check_eq("release_pulse", 32'(release_pulse), 32'(m_rel));
        check_eq("any_press", 32'(any_press), 32'(m_any));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    int hold [N];

    initial begin
        for (int i = 0; i < N; i++) anchor[i] = 0;

        // Reset with all buttons held, then release and measure latency.
        rst    = 1'b0;
        btn_in = 3'b111;
        steps(3);
        check_eq("rst_db", 32'(db_out), 32'h0);
        rst = 1'b1;
        steps(5);
        check_eq("rst_lat_db_early", 32'(db_out), 32'h0);
        step();
        check_eq("rst_lat_db", 32'(db_out), 32'h7);
        check_eq("rst_lat_press", 32'(press_pulse), 32'h7);
        check_eq("rst_lat_any", 32'(any_press), 32'h1);
        step();
        check_eq("rst_press_end", 32'(press_pulse), 32'h0);

        // Release everything, then a clean press on channel 0.
        btn_in = 3'b000;
        steps(8);
        btn_in[0] = 1'b1;
        steps(5);
        check_eq("press_db_early", 32'(db_out[0]), 32'h0);
        step();
        check_eq("press_db", 32'(db_out[0]), 32'h1);
        check_eq("press_pulse0", 32'(press_pulse[0]), 32'h1);
        step();
        check_eq("press_pulse0_end", 32'(press_pulse[0]), 32'h0);
        check_eq("press_any_end", 32'(any_press), 32'h0);

        // Bounce on channel 1: runs of three highs never qualify.
        for (int r = 0; r < 2; r++) begin
            btn_in[1] = 1'b1;
            steps(3);
            btn_in[1] = 1'b0;
            step();
        end
        steps(2);
        check_eq("bounce_db1", 32'(db_out[1]), 32'h0);
        btn_in[1] = 1'b1;
        steps(5);
        check_eq("bounce_db1_early", 32'(db_out[1]), 32'h0);
        step();
        check_eq("bounce_db1_rise", 32'(db_out[1]), 32'h1);

        // Clean release on channel 2 after it has been qualified high.
        btn_in[2] = 1'b1;
        steps(8);
        btn_in[2] = 1'b0;
        steps(5);
        check_eq("rel_early", 32'(release_pulse[2]), 32'h0);
        step();
        check_eq("rel_pulse2", 32'(release_pulse[2]), 32'h1);
        check_eq("rel_no_any", 32'(any_press), 32'h0);
        step();

        // Simultaneous press on channels 0 and 1, then reset mid-count on channel 2.
        btn_in = 3'b000;
        steps(8);
        btn_in = 3'b011;
        steps(6);
        check_eq("sim_db", 32'(db_out), 32'h3);
        check_eq("sim_any", 32'(any_press), 32'h1);
        step();
        check_eq("sim_any_end", 32'(any_press), 32'h0);
        btn_in[2] = 1'b1;
        steps(4);
        rst = 1'b0;
        steps(2);
        check_eq("mid_rst_db", 32'(db_out), 32'h0);
        rst = 1'b1;
        steps(5);
        check_eq("mid_rst_early", 32'(db_out[2]), 32'h0);
        step();
        check_eq("mid_rst_rise", 32'(db_out[2]), 32'h1);

        // Randomized bouncy buttons with occasional resets.
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    btn_in[i] = 1'($urandom_range(0, 1));
                    hold[i]   = (($urandom_range(0, 3) == 0) ? int'($urandom_range(S, 3 * S))
                                                              : int'($urandom_range(1, S + 1)));
                end
                hold[i]--;
            end
            rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
